// File: rtl/pwm_timer_ctrl.sv
// pwm_timer_ctrl: register file, prescaled timebase and double-buffered
// period/compare/function settings for the PWM generator.
//
// Optional feature macro: PWM_TIMER_CTRL_STATUS_EN
//   defined   -> STATUS (addr 6) holds a sticky wrap flag (bit0) and a sticky
//                overrun flag (bit1), both write-1-to-clear, set wins.
//   undefined -> STATUS reads 0 and writes to it are ignored.
//
// Config handshake: cfg_req is a single-cycle request sampled on a rising
// edge; cfg_ack is high for exactly the following cycle, for reads and
// writes alike. Write data lands in the shadow register on that same edge.
// Read data is the pre-write shadow value, registered alongside cfg_ack, and
// cfg_rdata holds its last value while cfg_ack is low. A new request may be
// issued on every cycle.
module pwm_timer_ctrl #(
    parameter int CW = 16,
    parameter int PW = 8,
    parameter int FW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_req,
    input  logic          cfg_we,
    input  logic [2:0]    cfg_addr,
    input  logic [15:0]   cfg_wdata,
    output logic [15:0]   cfg_rdata,
    output logic          cfg_ack,
    output logic          pwm_en,
    output logic [CW-1:0] period,
    output logic [FW-1:0] functions,
    output logic [CW-1:0] compare1,
    output logic [CW-1:0] compare2,
    output logic [CW-1:0] count_val,
    output logic          update_evt
);

    localparam logic [2:0] ADDR_CTRL      = 3'd0;
    localparam logic [2:0] ADDR_PERIOD    = 3'd1;
    localparam logic [2:0] ADDR_COMPARE1  = 3'd2;
    localparam logic [2:0] ADDR_COMPARE2  = 3'd3;
    localparam logic [2:0] ADDR_FUNCTIONS = 3'd4;
    localparam logic [2:0] ADDR_PRESCALE  = 3'd5;
    localparam logic [2:0] ADDR_STATUS    = 3'd6;

    // Shadow registers (software-visible)
    logic          en_q, en_d;
    logic [CW-1:0] period_sh_q, period_sh_d;
    logic [CW-1:0] cmp1_sh_q, cmp1_sh_d;
    logic [CW-1:0] cmp2_sh_q, cmp2_sh_d;
    logic [FW-1:0] func_sh_q, func_sh_d;
    logic [PW-1:0] presc_q, presc_d;

    // Active registers (seen by the generator)
    logic [CW-1:0] period_q, period_d;
    logic [CW-1:0] cmp1_q, cmp1_d;
    logic [CW-1:0] cmp2_q, cmp2_d;
    logic [FW-1:0] func_q, func_d;

    // Timebase
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] presc_cnt_q, presc_cnt_d;
    logic          update_evt_q, update_evt_d;
    logic          tick;
    logic          load_active;

    // Config port
    logic          cfg_ack_q, cfg_ack_d;
    logic [15:0]   cfg_rdata_q, cfg_rdata_d;
    logic [15:0]   rd_mux;
    logic [15:0]   status_rd;
    logic          wr_en;

    assign wr_en = cfg_req & cfg_we;

`ifdef PWM_TIMER_CTRL_STATUS_EN
    logic [1:0] status_q, status_d;
    logic [1:0] status_clr;

    // Sticky wrap/overrun flags; a set in the same cycle as a clear wins
    always_comb begin
        status_clr = (wr_en && cfg_addr == ADDR_STATUS) ? cfg_wdata[1:0] : 2'b00;
        status_d   = (status_q & ~status_clr)
                   | {update_evt_q & status_q[0], update_evt_q};
    end

    // Status flag storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) status_q <= 2'b00;
        else     status_q <= status_d;
    end

    assign status_rd = {14'd0, status_q};
`else
    assign status_rd = 16'd0;
`endif

    // Read multiplexer over the shadow registers
    always_comb begin
        rd_mux = 16'd0;
        case (cfg_addr)
            ADDR_CTRL:      rd_mux = {15'd0, en_q};
            ADDR_PERIOD:    rd_mux = 16'(period_sh_q);
            ADDR_COMPARE1:  rd_mux = 16'(cmp1_sh_q);
            ADDR_COMPARE2:  rd_mux = 16'(cmp2_sh_q);
            ADDR_FUNCTIONS: rd_mux = 16'(func_sh_q);
            ADDR_PRESCALE:  rd_mux = 16'(presc_q);
            ADDR_STATUS:    rd_mux = status_rd;
            default:        rd_mux = 16'd0;
        endcase
    end

    // Shadow register writes and registered read/ack response
    always_comb begin
        en_d        = en_q;
        period_sh_d = period_sh_q;
        cmp1_sh_d   = cmp1_sh_q;
        cmp2_sh_d   = cmp2_sh_q;
        func_sh_d   = func_sh_q;
        presc_d     = presc_q;
        cfg_ack_d   = cfg_req;
        cfg_rdata_d = cfg_rdata_q;
        if (cfg_req && !cfg_we) cfg_rdata_d = rd_mux;
        if (wr_en) begin
            case (cfg_addr)
                ADDR_CTRL:      en_d        = cfg_wdata[0];
                ADDR_PERIOD:    period_sh_d = cfg_wdata[CW-1:0];
                ADDR_COMPARE1:  cmp1_sh_d   = cfg_wdata[CW-1:0];
                ADDR_COMPARE2:  cmp2_sh_d   = cfg_wdata[CW-1:0];
                ADDR_FUNCTIONS: func_sh_d   = cfg_wdata[FW-1:0];
                ADDR_PRESCALE:  presc_d     = cfg_wdata[PW-1:0];
                default:        ;
            endcase
        end
    end

    // Prescaler, counter, and shadow-to-active transfer at a wrap
    always_comb begin
        tick         = (presc_cnt_q == presc_q);
        count_d      = count_q;
        presc_cnt_d  = presc_cnt_q;
        update_evt_d = 1'b0;
        load_active  = 1'b0;
        if (!en_q) begin
            // Idle: track the shadows so enabling starts from fresh values
            count_d     = '0;
            presc_cnt_d = '0;
            load_active = 1'b1;
        end else if (tick) begin
            presc_cnt_d = '0;
            if (count_q == period_q) begin
                count_d      = '0;
                load_active  = 1'b1;
                update_evt_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end else begin
            // Equality compare: a count above a newly lowered PRESCALE rolls over
            presc_cnt_d = presc_cnt_q + PW'(1);
        end
        period_d = load_active ? period_sh_q : period_q;
        cmp1_d   = load_active ? cmp1_sh_q   : cmp1_q;
        cmp2_d   = load_active ? cmp2_sh_q   : cmp2_q;
        func_d   = load_active ? func_sh_q   : func_q;
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q         <= 1'b0;
            period_sh_q  <= '0;
            cmp1_sh_q    <= '0;
            cmp2_sh_q    <= '0;
            func_sh_q    <= '0;
            presc_q      <= '0;
            period_q     <= '0;
            cmp1_q       <= '0;
            cmp2_q       <= '0;
            func_q       <= '0;
            count_q      <= '0;
            presc_cnt_q  <= '0;
            update_evt_q <= 1'b0;
            cfg_ack_q    <= 1'b0;
            cfg_rdata_q  <= 16'd0;
        end else begin
            en_q         <= en_d;
            period_sh_q  <= period_sh_d;
            cmp1_sh_q    <= cmp1_sh_d;
            cmp2_sh_q    <= cmp2_sh_d;
            func_sh_q    <= func_sh_d;
            presc_q      <= presc_d;
            period_q     <= period_d;
            cmp1_q       <= cmp1_d;
            cmp2_q       <= cmp2_d;
            func_q       <= func_d;
            count_q      <= count_d;
            presc_cnt_q  <= presc_cnt_d;
            update_evt_q <= update_evt_d;
            cfg_ack_q    <= cfg_ack_d;
            cfg_rdata_q  <= cfg_rdata_d;
        end
    end

    assign cfg_rdata  = cfg_rdata_q;
    assign cfg_ack    = cfg_ack_q;
    assign pwm_en     = en_q;
    assign period     = period_q;
    assign functions  = func_q;
    assign compare1   = cmp1_q;
    assign compare2   = cmp2_q;
    assign count_val  = count_q;
    assign update_evt = update_evt_q;

endmodule
